// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing defaults and receiver state encoding
//
// Purpose: one definition of bit timing and FSM states shared by the UART
// transmitter and receiver.
// Contents: CLK_PER_BIT_DEF, HALF_BIT_DEF (50 MHz / 9600 baud), rx_state_t.
package uart_pkg;

    localparam int CLK_PER_BIT_DEF = 5208;
    localparam int HALF_BIT_DEF    = 2604;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver result interface
//
// Purpose: groups the received-byte outputs of uart_rx.
// Signals: data_out[7:0] last good byte, data_valid one-cycle strobe,
//          frame_err one-cycle strobe, busy receiver not idle.
// Modports: master (driven by uart_rx), slave (consumer).
interface uart_rx_if;

    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input frame_err,
        input busy
    );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for the asynchronous serial line
//
// Purpose: brings rxd into the clk domain; resets to 1 so the line reads idle.
// Ports: clk, rst (sync, active-high), d async input, q synchronized output.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and break handling
//
// Purpose: receives LSB-first 8N1 frames on rxd, reports good bytes and
// framing errors.
// Params: CLK_PER_BIT clocks per bit, HALF_BIT clocks to start-bit mid-point.
// Ports: clk, rst (sync, active-high), rxd async serial line (idle high),
//        rx_if (master): data_out, data_valid, frame_err, busy.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int HALF_BIT    = HALF_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    uart_rx_if.master  rx_if
);

    localparam logic [15:0] BIT_END  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);

    logic        rxd_s;
    logic        rxd_prev;

    rx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  data_r, data_n;
    logic        dv_r, dv_n;
    logic        fe_r, fe_n;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            data_r   <= '0;
            dv_r     <= 1'b0;
            fe_r     <= 1'b0;
            rxd_prev <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            data_r   <= data_n;
            dv_r     <= dv_n;
            fe_r     <= fe_n;
            // Tracked in every state so a falling edge in the very cycle STOP
            // hands back to IDLE is still seen as 1->0.
            rxd_prev <= rxd_s;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data_r;
        dv_n    = 1'b0;
        fe_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (rxd_prev && !rxd_s) begin
                    state_n = ST_START;
                end
            end

            ST_START: begin
                if (cnt == HALF_END) begin
                    cnt_n = '0;
                    if (!rxd_s) begin
                        idx_n   = '0;
                        state_n = ST_DATA;
                    end else begin
                        // Start bit gone by its mid-point: treat as a glitch.
                        state_n = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rxd_s;
                    idx_n          = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        data_n  = shreg;
                        dv_n    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Wait out a held-low line; no edge can start a frame here.
                cnt_n = '0;
                if (rxd_s) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rx_if.data_out   = data_r;
    assign rx_if.data_valid = dv_r;
    assign rx_if.frame_err  = fe_r;
    assign rx_if.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_PER_BIT (CPB),
        .HALF_BIT    (HALF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rx_if (u_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    int         exp_fe   = 0;
    int         fe_seen  = 0;
    int         overlap  = 0;
    int         wide     = 0;
    int         fall_cyc = 0;
    logic       dv_d     = 1'b0;
    logic       fe_d     = 1'b0;

    // Output monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (u_if.data_valid) begin
            rx_q.push_back(u_if.data_out);
            rx_cyc_q.push_back(cyc);
        end
        if (u_if.frame_err) fe_seen++;
        if (u_if.data_valid && u_if.frame_err) overlap++;
        if ((u_if.data_valid && dv_d) || (u_if.frame_err && fe_d)) wide++;
        dv_d = u_if.data_valid;
        fe_d = u_if.frame_err;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference sender: bit k ends at round((k+1)*period) clocks after the
    // start-bit fall; period is given in hundredths of a clock. Called on a
    // negedge and returns on a negedge, so frames can abut with no gap.
    task automatic send_frame(input logic [7:0] b, input int per_x100, input int stop_low);
        logic [8:0] fr;
        int t;
        int endc;
        fr       = {b, 1'b0};
        t        = 0;
        fall_cyc = cyc;
        for (int i = 0; i < 9; i++) begin
            rxd  = fr[i];
            endc = ((i + 1) * per_x100 + 50) / 100;
            while (t < endc) begin
                @(negedge clk);
                t++;
            end
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            repeat (stop_low) @(negedge clk);
            rxd = 1'b1;
            exp_fe++;
        end else begin
            rxd  = 1'b1;
            endc = (10 * per_x100 + 50) / 100;
            while (t < endc) begin
                @(negedge clk);
                t++;
            end
            exp_q.push_back(b);
        end
    endtask

    // Compare everything received so far against the model's expectations.
    task automatic drain(input string tag);
        check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0)
            check_eq(tag, rx_q.pop_front(), exp_q.pop_front());
        rx_q.delete();
        exp_q.delete();
        rx_cyc_q.delete();
    endtask

    initial begin
        int lat;
        int t0;
        int gap;
        int busy_low;
        logic [7:0] b;
        int per;

        // Reset values
        repeat (4) @(negedge clk);
        check_eq("rst_data_out", u_if.data_out, 8'h00);
        check_eq("rst_data_valid", u_if.data_valid, 1'b0);
        check_eq("rst_frame_err", u_if.frame_err, 1'b0);
        check_eq("rst_busy", u_if.busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame 0xA5 and its latency
        send_frame(8'hA5, CPB * 100, 0);
        repeat (10) @(negedge clk);
        lat = (rx_cyc_q.size() > 0) ? rx_cyc_q[0] - fall_cyc : -1;
        check_eq("a5_latency_in_range", (lat >= 154 && lat <= 156), 1'b1);
        check_eq("a5_no_frame_err", fe_seen, 0);
        drain("a5_byte");

        // Back-to-back 0x00 then 0xFF with zero idle gap
        send_frame(8'h00, CPB * 100, 0);
        send_frame(8'hFF, CPB * 100, 0);
        repeat (10) @(negedge clk);
        gap = (rx_cyc_q.size() == 2) ? rx_cyc_q[1] - rx_cyc_q[0] : -1;
        check_eq("b2b_spacing", gap, 160);
        drain("b2b_byte");

        // 4-clock glitch on idle line
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        busy_low = 0;
        for (int i = 0; i < 11 && !busy_low; i++) begin
            @(negedge clk);
            if (!u_if.busy) busy_low = 1;
        end
        check_eq("glitch_busy_clears", busy_low, 1);
        repeat (40) @(negedge clk);
        check_eq("glitch_no_frame_err", fe_seen, exp_fe);
        drain("glitch_no_byte");

        // Framing error: 0x3C with stop held low for 48 clocks, then 0x81
        send_frame(8'h3C, CPB * 100, 48);
        // send_frame has released the line on this negedge; busy reflects
        // the state before the release reaches the synchronizer.
        check_eq("ferr_busy_while_low", u_if.busy, 1'b1);
        check_eq("ferr_pulse", fe_seen, exp_fe);
        check_eq("ferr_data_kept", u_if.data_out, 8'hFF);
        repeat (10) @(negedge clk);
        check_eq("ferr_busy_released", u_if.busy, 1'b0);
        drain("ferr_no_byte");
        send_frame(8'h81, CPB * 100, 0);
        repeat (10) @(negedge clk);
        drain("after_break");

        // Reset pulse during data bit 4 of 0xF0 (line high from bit 4 on)
        rxd = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (HALF) @(negedge clk);
        check_eq("midrst_busy_before", u_if.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_data_out", u_if.data_out, 8'h00);
        check_eq("midrst_busy", u_if.busy, 1'b0);
        check_eq("midrst_data_valid", u_if.data_valid, 1'b0);
        check_eq("midrst_frame_err", u_if.frame_err, 1'b0);
        rst = 1'b0;
        repeat (8 * CPB) @(negedge clk);
        drain("midrst_no_byte");
        send_frame(8'h5A, CPB * 100, 0);
        repeat (10) @(negedge clk);
        drain("midrst_next");

        // Baud skew of +/-3% over 20 random bytes
        for (int i = 0; i < 20; i++) begin
            b   = 8'($urandom_range(0, 255));
            per = ($urandom_range(0, 1) == 0) ? (CPB * 97) : (CPB * 103);
            send_frame(b, per, 0);
            repeat (4) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        drain("skew");

        // Whole-run properties
        check_eq("total_frame_errs", fe_seen, exp_fe);
        check_eq("no_dv_fe_overlap", overlap, 0);
        check_eq("pulses_one_cycle", wide, 0);

        t0 = cyc;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 5208, system clocks per bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter HALF_BIT, default 2604, clocks from start-bit falling edge to the start-bit mid-point.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 SHALL have port data_out  output  8  last correctly received byte.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse; data_out is new this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass rxd through a two-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-012 IDLE: on rxd_s 1->0 (previous 1, current 0), SHALL clear the bit counter cnt to 0 and enter START.
REQ-013 START: when cnt == HALF_BIT-1, if rxd_s == 0 SHALL clear cnt, clear the bit index, and enter DATA; if rxd_s == 1 (glitch) SHALL return to IDLE with no output pulse.
REQ-014 DATA: when cnt == CLK_PER_BIT-1, SHALL shift rxd_s into bit position index, clear cnt, and increment index; after index 7 is sampled SHALL enter STOP.
REQ-015 STOP: when cnt == CLK_PER_BIT-1, the block SHALL act on the stop-bit sample as follows:
- rxd_s == 1: SHALL load data_out with the shift register, pulse data_valid and enter IDLE the same cycle.
- rxd_s == 0: SHALL pulse frame_err, leave data_out unchanged and enter BREAK.
REQ-016 BREAK: SHALL stay until rxd_s == 1, then enter IDLE; no falling edge is accepted while in BREAK.
REQ-017 cnt SHALL be 16 bits wide, count up by 1 per clock, and never wrap within a bit period.
REQ-018 Each sample SHALL land at the bit mid-point, ±1 clock.
REQ-019 Latency SHALL be HALF_BIT + 9*CLK_PER_BIT + 3 clocks (±1) from the rxd pin falling edge to data_valid.
REQ-020 A falling edge arriving in the cycle STOP returns to IDLE SHALL be detected, giving back-to-back frames with zero idle gap.
REQ-021 data_valid and frame_err SHALL never be high in the same cycle and SHALL each be exactly one cycle wide.
REQ-022 rxd transitions outside the sample instants SHALL have no effect in DATA or STOP.

Reset
REQ-023 While rst is high, the block SHALL hold the following values:
- state IDLE, cnt 0, index 0, shift register 0.
- data_out 8'h00, data_valid 0, frame_err 0, busy 0.
- both synchronizer flops 1 (idle line).
REQ-024 rst asserted mid-frame SHALL abort the frame at the next edge with no output pulse; reception resumes with the next falling edge after rst deasserts.

Structure
REQ-025 A shared package uart_pkg SHALL hold the following items, so that the transmitter and this block share one definition:
- CLK_PER_BIT default 5208 and HALF_BIT default 2604.
- the state encoding (IDLE/START/DATA/STOP/BREAK).
REQ-026 The synchronizer SHALL be a separate sub-module uart_sync2 (1-bit in, 1-bit out, reset value 1); everything else is in uart_rx.

Verification (CLK_PER_BIT=16, HALF_BIT=8)
REQ-027 Send 0xA5 as 8N1 at 16 clk/bit -> single data_valid pulse, data_out==8'hA5, frame_err stays 0, latency 155 ±1 clocks.
REQ-028 Send 0x00 then 0xFF back-to-back with zero idle gap -> two data_valid pulses exactly 160 clocks apart, data_out 8'h00 then 8'hFF.
REQ-029 Drive a 4-clock low glitch on idle rxd -> no data_valid, no frame_err, busy returns to 0 within 11 clocks.
REQ-030 Send 0x3C with the stop bit held low for 48 clocks -> frame_err pulse, data_out keeps its previous value, busy stays high until rxd returns high, then the next frame 0x81 is received correctly.
REQ-031 Assert rst for 1 cycle during data bit 4 of a frame -> no pulse for that frame, all outputs at reset values; the following frame 0x5A is received correctly.
REQ-032 Skew the sender baud by ±3% over 20 random bytes -> all bytes received, no frame_err.
